// File: rtl/GLOBAL.sv
// Shared types for the game/renderer boundary: board cells, the board itself and the
// next-piece descriptor, plus the default visible line count.
package GLOBAL;

  localparam int unsigned FIELD_ROWS       = 22;
  localparam int unsigned FIELD_COLS       = 10;
  localparam int unsigned V_ACTIVE_DEFAULT = 800;

  typedef logic [2:0] cell_t;

  localparam cell_t TETROMINO_EMPTY = 3'd7;

  // Rows include the hidden spawn rows above the visible board.
  typedef cell_t [FIELD_ROWS-1:0][FIELD_COLS-1:0] field_t;

  typedef struct packed {
    cell_t       kind;
    logic [1:0]  rot;
    logic [4:0]  row;
    logic [3:0]  col;
  } tetromino_ctrl;

endpackage

// File: rtl/display_frame_ctrl_pkg.sv
// Local types and helpers for display_frame_ctrl.
package display_frame_ctrl_pkg;
  import GLOBAL::*;

  typedef enum logic [1:0] {
    StScan,
    StOpen,
    StDone
  } frame_state_e;

  function automatic field_t empty_field();
    field_t f;
    for (int r = 0; r < FIELD_ROWS; r++) begin
      for (int c = 0; c < FIELD_COLS; c++) begin
        f[r][c] = TETROMINO_EMPTY;
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Game-over blink phase generator: toggles phase every BLINK_FRAMES ticks while enabled.
// Only built when DISPLAY_BLINK_EN is defined.
`ifdef DISPLAY_BLINK_EN
module blink_timer #(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic tick,
  output logic phase
);

  localparam logic [15:0] LastCount = 16'(BLINK_FRAMES - 1);

  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      phase   <= 1'b0;
    end else if (!enable) begin
      count_q <= '0;
      phase   <= 1'b0;
    end else if (tick) begin
      if (count_q == LastCount) begin
        count_q <= '0;
        phase   <= ~phase;
      end else begin
        count_q <= count_q + 16'd1;
      end
    end
  end

endmodule
`endif

// File: rtl/display_frame_ctrl.sv
// Frame-synchronous snapshot of game state into shadow registers during vertical blanking.
// Optional game-over blink selected by DISPLAY_BLINK_EN.
module display_frame_ctrl
  import GLOBAL::*;
  import display_frame_ctrl_pkg::*;
#(
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEFAULT,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    curr_y,
  input  logic          upd_valid,
  output logic          upd_ready,
  input  field_t        field_in,
  input  logic [31:0]   score_in,
  input  tetromino_ctrl t_next_in,
  input  logic [3:0]    level_in,
  input  logic          game_over_in,
  output field_t        display,
  output logic [31:0]   score,
  output tetromino_ctrl t_next,
  output logic [3:0]    current_level,
  output logic          game_over,
  output logic          vblank_start,
  output logic [15:0]   frame_cnt,
  output logic          dropped
);

  localparam logic [9:0] VActive = 10'(V_ACTIVE);

  frame_state_e state_q, state_d;
  logic [9:0]   curr_y_d;
  logic         primed_q;
  logic         go_shadow_q;
  logic         blank_now, blank_edge, handshake;
  logic         upd_ready_d, dropped_d;

  assign blank_now  = curr_y >= VActive;
  // primed_q masks the first cycle after reset so a reset inside blanking never opens it.
  assign blank_edge = primed_q && blank_now && (curr_y_d < VActive);
  assign handshake  = upd_valid && upd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StScan;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving blanking wins over a same-cycle handshake, so that capture lands in SCAN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StScan: if (blank_edge) state_d = StOpen;
      StOpen: begin
        if (!blank_now)     state_d = StScan;
        else if (handshake) state_d = StDone;
      end
      StDone: if (!blank_now) state_d = StScan;
      default: state_d = StScan;
    endcase
  end

  always_comb begin
    upd_ready_d = (state_q == StOpen) && (state_d == StOpen);
    dropped_d   = dropped ||
                  ((state_q == StOpen) && !blank_now && upd_valid && !handshake);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curr_y_d      <= 10'(V_ACTIVE - 1);
      primed_q      <= 1'b0;
      upd_ready     <= 1'b0;
      vblank_start  <= 1'b0;
      frame_cnt     <= '0;
      dropped       <= 1'b0;
      display       <= empty_field();
      score         <= '0;
      t_next        <= '0;
      current_level <= '0;
      go_shadow_q   <= 1'b0;
    end else begin
      curr_y_d     <= curr_y;
      primed_q     <= 1'b1;
      upd_ready    <= upd_ready_d;
      vblank_start <= blank_edge;
      dropped      <= dropped_d;
      if (blank_edge) frame_cnt <= frame_cnt + 16'd1;
      if (handshake) begin
        display       <= field_in;
        score         <= score_in;
        t_next        <= t_next_in;
        current_level <= level_in;
        go_shadow_q   <= game_over_in;
      end
    end
  end

`ifdef DISPLAY_BLINK_EN
  logic blink_phase;

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(go_shadow_q),
    .tick  (vblank_start),
    .phase (blink_phase)
  );

  assign game_over = go_shadow_q && !blink_phase;
`else
  logic unused_cfg;
  assign unused_cfg = ^BLINK_FRAMES;
  assign game_over  = go_shadow_q;
`endif

endmodule

// File: tb/tb_display_frame_ctrl.sv
// Bench for display_frame_ctrl: directed literal checks plus randomized frames against a
// window-based reference model compared on every cycle.
module tb_display_frame_ctrl;
  import GLOBAL::*;

  localparam int unsigned VA = 800;
  localparam int unsigned BF = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [9:0]    curr_y;
  logic          upd_valid;
  logic          upd_ready;
  field_t        field_in;
  logic [31:0]   score_in;
  tetromino_ctrl t_next_in;
  logic [3:0]    level_in;
  logic          game_over_in;
  field_t        display;
  logic [31:0]   score;
  tetromino_ctrl t_next;
  logic [3:0]    current_level;
  logic          game_over;
  logic          vblank_start;
  logic [15:0]   frame_cnt;
  logic          dropped;

  int pass_cnt  = 0;
  int total_cnt = 0;

  display_frame_ctrl #(
    .V_ACTIVE    (VA),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .curr_y       (curr_y),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .field_in     (field_in),
    .score_in     (score_in),
    .t_next_in    (t_next_in),
    .level_in     (level_in),
    .game_over_in (game_over_in),
    .display      (display),
    .score        (score),
    .t_next       (t_next),
    .current_level(current_level),
    .game_over    (game_over),
    .vblank_start (vblank_start),
    .frame_cnt    (frame_cnt),
    .dropped      (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic field_t all_empty();
    field_t f;
    for (int r = 0; r < 22; r++) for (int c = 0; c < 10; c++) f[r][c] = 3'b111;
    return f;
  endfunction

  function automatic field_t rand_field();
    field_t f;
    for (int r = 0; r < 22; r++) for (int c = 0; c < 10; c++) f[r][c] = 3'($urandom_range(0, 7));
    return f;
  endfunction

  // ---------------- reference model ----------------
  field_t        m_display;
  logic [31:0]   m_score;
  tetromino_ctrl m_tnext;
  logic [3:0]    m_level;
  logic          m_go;
  logic          m_vblank;
  logic [15:0]   m_frame;
  logic          m_dropped;
  logic          m_ready;
  int            m_ticks;
  bit            m_have_prev;
  logic [9:0]    m_prev_y;
  bit            m_in_win;
  bit            m_captured;
  int            m_age;

  function automatic logic exp_game_over();
`ifdef DISPLAY_BLINK_EN
    return m_go && (((m_ticks / BF) % 2) == 0);
`else
    return m_go;
`endif
  endfunction

  task automatic model_reset();
    m_display = all_empty(); m_score = 0; m_tnext = '0; m_level = 0; m_go = 0;
    m_vblank = 0; m_frame = 0; m_dropped = 0; m_ready = 0; m_ticks = 0;
    m_have_prev = 0; m_prev_y = 0; m_in_win = 0; m_captured = 0; m_age = 0;
  endtask

  task automatic model_step();
    bit capture, bedge;
    capture = m_ready && upd_valid;
    bedge   = m_have_prev && (curr_y >= 10'(VA)) && (m_prev_y < 10'(VA));
    if (m_go) begin
      if (m_vblank) m_ticks++;
    end else begin
      m_ticks = 0;
    end
    if (capture) begin
      m_display = field_in; m_score = score_in; m_tnext = t_next_in;
      m_level = level_in; m_go = game_over_in; m_captured = 1;
    end
    // Window closes on the first visible line; an unanswered offer there is a drop.
    if (m_in_win && curr_y < 10'(VA)) begin
      if (!m_captured && upd_valid) m_dropped = 1;
      m_in_win = 0;
    end
    m_vblank = bedge;
    if (bedge) begin
      m_frame++;
      m_in_win = 1; m_age = 0; m_captured = 0;
    end else if (m_in_win) begin
      m_age++;
    end
    m_ready     = m_in_win && !m_captured && (m_age >= 1);
    m_prev_y    = curr_y;
    m_have_prev = 1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("upd_ready", upd_ready, m_ready);
    chk("display", display, m_display);
    chk("score", score, m_score);
    chk("t_next", t_next, m_tnext);
    chk("current_level", current_level, m_level);
    chk("game_over", game_over, exp_game_over());
    chk("vblank_start", vblank_start, m_vblank);
    chk("frame_cnt", frame_cnt, m_frame);
    chk("dropped", dropped, m_dropped);
    if (rst_n) model_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick_y(input int y);
    curr_y = 10'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic new_data();
    field_in     = rand_field();
    score_in     = $urandom;
    t_next_in    = tetromino_ctrl'(14'($urandom));
    level_in     = 4'($urandom);
    game_over_in = ($urandom_range(0, 3) == 0);
  endtask

  // Game logic: holds an offer until accepted, occasionally raises a new one.
  task automatic rcycle(input int y);
    bit hs;
    curr_y = 10'(y);
    if (!upd_valid && $urandom_range(0, 3) == 0) begin
      new_data();
      upd_valid = 1'b1;
    end
    hs = upd_valid && upd_ready;
    @(posedge clk);
    #1;
    if (hs) upd_valid = 1'b0;
  endtask

  logic exp_blink [5];

  initial begin
    rst_n = 1'b0; curr_y = 10'd850; upd_valid = 1'b0;
    new_data(); game_over_in = 1'b0;
    model_reset();

    // Reset inside blanking: nothing opens until the next 799->800 crossing.
    tick_y(850); tick_y(850);
    chk("rst_display", display, all_empty());
    chk("rst_score", score, 32'd0);
    chk("rst_frame", frame_cnt, 16'd0);
    rst_n = 1'b1;
    tick_y(850); chk("post_rst_ready_a", upd_ready, 1'b0);
    tick_y(900); chk("post_rst_ready_b", upd_ready, 1'b0);
    tick_y(10); tick_y(799);
    tick_y(800);
    chk("vbs_pulse", vblank_start, 1'b1);
    chk("ready_lat1", upd_ready, 1'b0);
    chk("frame_one", frame_cnt, 16'd1);
    tick_y(801); chk("ready_lat2", upd_ready, 1'b1);
    tick_y(0);

    // Offer held from line 400 is captured two cycles after line 800.
    new_data(); game_over_in = 1'b0; score_in = 32'd1234; upd_valid = 1'b1;
    tick_y(400); tick_y(799);
    tick_y(800); chk("score_hold_a", score, 32'd0);
    tick_y(801); chk("score_hold_b", score, 32'd0);
    tick_y(802); chk("score_cap", score, 32'd1234); chk("ready_done", upd_ready, 1'b0);
    upd_valid = 1'b0;
    tick_y(803); chk("ready_done2", upd_ready, 1'b0);
    tick_y(0);

    // Two offers in one window: second waits for the next frame, no drop.
    score_in = 32'd111; upd_valid = 1'b1;
    tick_y(800); tick_y(801); tick_y(802);
    chk("first_cap", score, 32'd111);
    score_in = 32'd222;
    tick_y(803); tick_y(0);
    chk("second_wait", score, 32'd111); chk("no_drop_a", dropped, 1'b0);
    tick_y(5); tick_y(800); tick_y(801); tick_y(802);
    chk("second_cap", score, 32'd222);
    upd_valid = 1'b0;
    tick_y(0);

    // Offer on the last ready cycle is taken; one cycle later waits a frame.
    tick_y(800); tick_y(801); tick_y(802);
    score_in = 32'd333; upd_valid = 1'b1;
    tick_y(0);
    chk("last_cap", score, 32'd333); chk("last_ready", upd_ready, 1'b0);
    upd_valid = 1'b0;
    tick_y(800); tick_y(801); tick_y(802);
    tick_y(0);
    score_in = 32'd444; upd_valid = 1'b1;
    tick_y(1); chk("late_wait", score, 32'd333);
    tick_y(2); tick_y(800); tick_y(801); tick_y(802);
    chk("late_cap", score, 32'd444); chk("no_drop_b", dropped, 1'b0);
    upd_valid = 1'b0;
    tick_y(0);

    // Mid-window reset suppresses the window: no drop; a one-line window with an offer drops.
    score_in = 32'd555; upd_valid = 1'b1;
    tick_y(800);
    rst_n = 1'b0; tick_y(801); tick_y(802);
    rst_n = 1'b1; tick_y(803); tick_y(804);
    chk("rst_win_ready", upd_ready, 1'b0);
    tick_y(0);
    chk("rst_win_nodrop", dropped, 1'b0); chk("rst_win_score", score, 32'd0);
    tick_y(800); tick_y(801); tick_y(802);
    chk("after_rst_cap", score, 32'd555);
    score_in = 32'd666;
    tick_y(0); tick_y(800); tick_y(0);
    chk("drop_set", dropped, 1'b1); chk("drop_score", score, 32'd555);
    tick_y(800); tick_y(801); tick_y(802);
    chk("drop_cap", score, 32'd666); chk("drop_sticky", dropped, 1'b1);
    upd_valid = 1'b0;

    // Game-over blink across successive frames.
`ifdef DISPLAY_BLINK_EN
    exp_blink = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    exp_blink = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    rst_n = 1'b0; tick_y(0); rst_n = 1'b1; tick_y(0);
    game_over_in = 1'b1; upd_valid = 1'b1;
    tick_y(800); tick_y(801); tick_y(802);
    upd_valid = 1'b0;
    chk("blink_f0", game_over, exp_blink[0]);
    for (int k = 1; k < 5; k++) begin
      tick_y(0); tick_y(10); tick_y(800); tick_y(801);
      chk($sformatf("blink_f%0d", k), game_over, exp_blink[k]);
    end
    tick_y(0);

    // Randomized frames with occasional mid-blanking resets.
    for (int f = 0; f < 300; f++) begin
      int na, nb;
      na = $urandom_range(1, 6);
      nb = $urandom_range(1, 5);
      for (int i = 0; i < na; i++) rcycle($urandom_range(0, 799));
      for (int i = 0; i < nb; i++) begin
        if (i == 1 && $urandom_range(0, 24) == 0) begin
          rst_n = 1'b0;
          rcycle($urandom_range(800, 1023));
          rst_n = 1'b1;
        end else begin
          rcycle($urandom_range(800, 1023));
        end
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
